// File: rtl/conv_layer_mem_pkg.sv
// Shared constants, bank-select encodings and dump states for conv_layer_mem.
// Bank depths are looked up via depth_of(); an illegal select has depth 0.
package conv_layer_mem_pkg;

    localparam int DATA_WIDTH = 20;
    localparam int ADDR_WIDTH = 12;
    localparam int L0_DEPTH   = 4096;
    localparam int L1_DEPTH   = 1024;
    localparam int L2_DEPTH   = 2048;

    localparam logic [2:0] CSEL_L0K0 = 3'b001;
    localparam logic [2:0] CSEL_L0K1 = 3'b010;
    localparam logic [2:0] CSEL_L1K0 = 3'b011;
    localparam logic [2:0] CSEL_L1K1 = 3'b100;
    localparam logic [2:0] CSEL_L2   = 3'b101;

    typedef enum logic [1:0] {
        D_IDLE,
        D_RD,
        D_OUT,
        D_DONE
    } dump_state_t;

    // Zero depth for an illegal select makes every address out of range.
    function automatic logic [ADDR_WIDTH:0] depth_of(input logic [2:0] sel);
        case (sel)
            CSEL_L0K0, CSEL_L0K1: depth_of = (ADDR_WIDTH+1)'(L0_DEPTH);
            CSEL_L1K0, CSEL_L1K1: depth_of = (ADDR_WIDTH+1)'(L1_DEPTH);
            CSEL_L2:              depth_of = (ADDR_WIDTH+1)'(L2_DEPTH);
            default:              depth_of = '0;
        endcase
    endfunction

endpackage

// File: rtl/conv_layer_mem_bank.sv
// One result bank: a write port and two registered read ports (CONV, dump).
// WR_FWD_EN: a read colliding with a same-cycle write returns the new data.
module conv_layer_mem_bank
    import conv_layer_mem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re_a,
    input  logic [$clog2(DEPTH)-1:0] i_raddr_a,
    input  logic                  i_re_b,
    input  logic [$clog2(DEPTH)-1:0] i_raddr_b,
    output logic [DATA_WIDTH-1:0] o_rdata_a,
    output logic [DATA_WIDTH-1:0] o_rdata_b
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata_a;
    logic [DATA_WIDTH-1:0] r_rdata_b;
    logic [DATA_WIDTH-1:0] w_next_a;
    logic [DATA_WIDTH-1:0] w_next_b;

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read data as seen this cycle, optionally bypassing a colliding write.
    always_comb begin
        w_next_a = r_mem[i_raddr_a];
        w_next_b = r_mem[i_raddr_b];
`ifdef WR_FWD_EN
        if (i_we && (i_waddr == i_raddr_a)) begin
            w_next_a = i_wdata;
        end
        if (i_we && (i_waddr == i_raddr_b)) begin
            w_next_b = i_wdata;
        end
`endif
    end

    // Read registers only load on their own strobe, so they hold otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            if (i_re_a) begin
                r_rdata_a <= w_next_a;
            end
            if (i_re_b) begin
                r_rdata_b <= w_next_b;
            end
        end
    end

    assign o_rdata_a = r_rdata_a;
    assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/conv_layer_mem.sv
// CONV layer memory: five result banks, access decode, sticky err, dump engine.
// Optional macro WR_FWD_EN selects new-data return on read/write collisions.
module conv_layer_mem
    import conv_layer_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  conv_busy,
    input  logic [2:0]            csel,
    input  logic                  cwr,
    input  logic [ADDR_WIDTH-1:0] caddr_wr,
    input  logic [DATA_WIDTH-1:0] cdata_wr,
    input  logic                  crd,
    input  logic [ADDR_WIDTH-1:0] caddr_rd,
    output logic [DATA_WIDTH-1:0] cdata_rd,
    input  logic                  dump_start,
    input  logic [2:0]            dump_sel,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic                  dump_done,
    output logic                  dump_abort,
    output logic                  err
);

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_conv_bad;
    logic                  w_dstart;
    logic                  w_dsel_ok;
    logic                  w_dlast;
    logic                  w_drd;
    logic [ADDR_WIDTH:0]   w_ddepth;
    logic [DATA_WIDTH-1:0] w_rda [8];
    logic [DATA_WIDTH-1:0] w_rdb [8];

    logic [2:0]            r_rd_bank;
    logic [2:0]            r_dsel;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_valid;
    logic                  r_done;
    logic                  r_abort;
    logic                  r_err;
    dump_state_t           r_state;

    assign w_wr_ok    = cwr && ({1'b0, caddr_wr} < depth_of(csel));
    assign w_rd_ok    = crd && ({1'b0, caddr_rd} < depth_of(csel));
    assign w_conv_bad = (cwr && !w_wr_ok) || (crd && !w_rd_ok);
    assign w_dstart   = dump_start && !conv_busy && (r_state == D_IDLE);
    assign w_dsel_ok  = depth_of(dump_sel) != '0;
    assign w_ddepth   = depth_of(r_dsel);
    assign w_dlast    = {1'b0, r_addr} == (w_ddepth - (ADDR_WIDTH+1)'(1));
    assign w_drd      = r_state == D_RD;

    // Unused select codes read as zero.
    assign w_rda[0] = '0;
    assign w_rda[6] = '0;
    assign w_rda[7] = '0;
    assign w_rdb[0] = '0;
    assign w_rdb[6] = '0;
    assign w_rdb[7] = '0;

    for (genvar g = 1; g < 6; g++) begin : g_bank
        localparam logic [2:0] SEL = 3'(g);
        localparam int DEP = int'(depth_of(SEL));
        localparam int IW  = $clog2(DEP);
        conv_layer_mem_bank #(.DEPTH(DEP)) u_bank (
            .clk       (clk),
            .reset     (reset),
            .i_we      (w_wr_ok && (csel == SEL)),
            .i_waddr   (caddr_wr[IW-1:0]),
            .i_wdata   (cdata_wr),
            .i_re_a    (w_rd_ok && (csel == SEL)),
            .i_raddr_a (caddr_rd[IW-1:0]),
            .i_re_b    (w_drd && (r_dsel == SEL)),
            .i_raddr_b (r_addr[IW-1:0]),
            .o_rdata_a (w_rda[g]),
            .o_rdata_b (w_rdb[g])
        );
    end

    // Track which bank the last CONV read hit (0 = illegal) and latch errors.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_bank <= '0;
            r_err     <= 1'b0;
        end else begin
            if (crd) begin
                r_rd_bank <= w_rd_ok ? csel : 3'b000;
            end
            if (w_conv_bad || (w_dstart && !w_dsel_ok)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Dump engine; busy is low when a dump starts, so busy high here is a rise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= D_IDLE;
            r_dsel  <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            if ((r_state != D_IDLE) && conv_busy) begin
                r_state <= D_IDLE;
                r_valid <= 1'b0;
                r_abort <= 1'b1;
            end else begin
                unique case (r_state)
                    D_IDLE: begin
                        if (w_dstart && w_dsel_ok) begin
                            r_dsel  <= dump_sel;
                            r_addr  <= '0;
                            r_state <= D_RD;
                        end
                    end
                    D_RD: begin
                        r_state <= D_OUT;
                        r_valid <= 1'b1;
                    end
                    D_OUT: begin
                        if (dump_ready) begin
                            r_valid <= 1'b0;
                            if (w_dlast) begin
                                r_state <= D_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_addr  <= r_addr + ADDR_WIDTH'(1);
                                r_state <= D_RD;
                            end
                        end
                    end
                    D_DONE: begin
                        r_state <= D_IDLE;
                    end
                endcase
            end
        end
    end

    assign cdata_rd   = w_rda[r_rd_bank];
    assign dump_data  = w_rdb[r_dsel];
    assign dump_addr  = r_addr;
    assign dump_valid = r_valid;
    assign dump_done  = r_done;
    assign dump_abort = r_abort;
    assign err        = r_err;

endmodule

// File: tb/tb_conv_layer_mem.sv
// Bench for conv_layer_mem: array model of the banks, per-cycle compare,
// random CONV traffic, dump stream scoreboard and a few literal checks.
module tb_conv_layer_mem;

    logic        clk = 1'b0;
    logic        reset, conv_busy, cwr, crd, dump_start, dump_ready;
    logic [2:0]  csel, dump_sel;
    logic [11:0] caddr_wr, caddr_rd;
    logic [19:0] cdata_wr;
    logic [19:0] cdata_rd, dump_data;
    logic [11:0] dump_addr;
    logic        dump_valid, dump_done, dump_abort, err;

    always #5 clk = ~clk;

    conv_layer_mem dut (
        .clk        (clk),
        .reset      (reset),
        .conv_busy  (conv_busy),
        .csel       (csel),
        .cwr        (cwr),
        .caddr_wr   (caddr_wr),
        .cdata_wr   (cdata_wr),
        .crd        (crd),
        .caddr_rd   (caddr_rd),
        .cdata_rd   (cdata_rd),
        .dump_start (dump_start),
        .dump_sel   (dump_sel),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_addr  (dump_addr),
        .dump_done  (dump_done),
        .dump_abort (dump_abort),
        .err        (err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: plain arrays indexed by bank select and address.
    logic [19:0] mm [8][4096];
    bit          kn [8][4096];
    logic [19:0] e_cd  = '0;
    bit          e_kn  = 1'b1;
    bit          e_err = 1'b0;
    bit          m_wok, m_rok;
    bit          chk_en = 1'b0;

    function automatic int dep(input logic [2:0] s);
        case (s)
            3'd1, 3'd2: return 4096;
            3'd3, 3'd4: return 1024;
            3'd5:       return 2048;
            default:    return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            e_cd  = '0;
            e_kn  = 1'b1;
            e_err = 1'b0;
        end else begin
            m_wok = cwr && (int'(caddr_wr) < dep(csel));
            m_rok = crd && (int'(caddr_rd) < dep(csel));
            if ((cwr && !m_wok) || (crd && !m_rok)) e_err = 1'b1;
            if (crd) begin
                if (!m_rok) begin
                    e_cd = '0;
                    e_kn = 1'b1;
                end else begin
                    e_cd = mm[csel][caddr_rd];
                    e_kn = kn[csel][caddr_rd];
`ifdef WR_FWD_EN
                    if (m_wok && (caddr_wr == caddr_rd)) begin
                        e_cd = cdata_wr;
                        e_kn = 1'b1;
                    end
`endif
                end
            end
            if (m_wok) begin
                mm[csel][caddr_wr] = cdata_wr;
                kn[csel][caddr_wr] = 1'b1;
            end
        end
    end

    // Dump scoreboard: words must come out in address order from bank d_bank.
    logic [2:0] d_bank = '0;
    int d_idx   = 0;
    int n_words = 0;
    int n_done  = 0;
    int n_abort = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (e_kn) chk("cdata_rd", 32'(cdata_rd), 32'(e_cd));
            chk("err", 32'(err), 32'(e_err));
            if (dump_valid) begin
                chk("dump_addr", 32'(dump_addr), 32'(d_idx));
                if (kn[d_bank][d_idx[11:0]])
                    chk("dump_data", 32'(dump_data), 32'(mm[d_bank][d_idx[11:0]]));
                if (dump_ready) begin
                    d_idx++;
                    n_words++;
                end
            end
            if (dump_done) n_done++;
            if (dump_abort) n_abort++;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_dump(input logic [2:0] s);
        d_bank = s;
        d_idx = 0;
        n_words = 0;
        n_done = 0;
        n_abort = 0;
        dump_sel = s;
        dump_start = 1'b1;
        cyc();
        dump_start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; conv_busy = 1'b0; cwr = 1'b0; crd = 1'b0;
        csel = '0; caddr_wr = '0; caddr_rd = '0; cdata_wr = '0;
        dump_start = 1'b0; dump_sel = '0; dump_ready = 1'b0;
        cyc(2);
        chk("rst_cdata_rd", 32'(cdata_rd), 32'd0);
        chk("rst_valid", 32'(dump_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_done", 32'(dump_done), 32'd0);
        chk("rst_abort", 32'(dump_abort), 32'd0);
        reset = 1'b1;
        chk_en = 1'b1;

        // Write then read back, L0K0 and the top of L2.
        csel = 3'd1; cwr = 1'b1; caddr_wr = 12'd5; cdata_wr = 20'h0ABCD;
        cyc();
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd5;
        cyc();
        crd = 1'b0;
        chk("t2_l0k0", 32'(cdata_rd), 32'h0ABCD);
        cyc();
        chk("t2_hold", 32'(cdata_rd), 32'h0ABCD);
        csel = 3'd5; cwr = 1'b1; caddr_wr = 12'd2047; cdata_wr = 20'h12345;
        cyc();
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd2047;
        cyc();
        crd = 1'b0;
        chk("t2_l2", 32'(cdata_rd), 32'h12345);
        chk("t2_err", 32'(err), 32'd0);

        // Out-of-range and illegal select.
        csel = 3'd3; cwr = 1'b1; caddr_wr = 12'd1024; cdata_wr = 20'h77777;
        cyc();
        cwr = 1'b0;
        chk("t3_err", 32'(err), 32'd1);
        crd = 1'b1; caddr_rd = 12'd1024;
        cyc();
        crd = 1'b0;
        chk("t3_rd0", 32'(cdata_rd), 32'd0);
        csel = 3'd6; cwr = 1'b1; caddr_wr = 12'd0;
        cyc();
        cwr = 1'b0;
        chk("t3_sticky", 32'(err), 32'd1);

        // Random CONV traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cwr = 1'($urandom_range(0, 1));
            crd = 1'($urandom_range(0, 1));
            csel = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                               : 3'($urandom_range(1, 5));
            caddr_wr = ($urandom_range(0, 3) == 0) ? 12'($urandom)
                                                   : 12'($urandom_range(0, 15));
            caddr_rd = ($urandom_range(0, 3) == 0) ? 12'($urandom)
                                                   : 12'($urandom_range(0, 15));
            cdata_wr = 20'($urandom);
            cyc();
        end
        cwr = 1'b0; crd = 1'b0;

        // Same-cycle write and read of one address.
        csel = 3'd1; cwr = 1'b1; caddr_wr = 12'd7; cdata_wr = 20'd1;
        cyc();
        crd = 1'b1; caddr_rd = 12'd7; cdata_wr = 20'd2;
        cyc();
        cwr = 1'b0; crd = 1'b0;
`ifdef WR_FWD_EN
        chk("t6_collide", 32'(cdata_rd), 32'd2);
`else
        chk("t6_collide", 32'(cdata_rd), 32'd1);
`endif

        // Fill L1K1 and the low part of L0K0.
        cwr = 1'b1;
        csel = 3'd4;
        for (int i = 0; i < 1024; i++) begin
            caddr_wr = 12'(i);
            cdata_wr = 20'(i) ^ 20'h5A5A;
            cyc();
        end
        csel = 3'd1;
        for (int i = 0; i < 16; i++) begin
            caddr_wr = 12'(i);
            cdata_wr = 20'(i * 3 + 1);
            cyc();
        end
        cwr = 1'b0;

        // Full dump of L1K1 with random ready and concurrent CONV reads.
        start_dump(3'd4);
        for (int k = 0; k < 8000 && n_done == 0; k++) begin
            dump_ready = 1'($urandom_range(0, 1));
            crd = 1'($urandom_range(0, 1));
            caddr_rd = 12'($urandom_range(0, 15));
            cyc();
        end
        crd = 1'b0;
        dump_ready = 1'b0;
        cyc(4);
        chk("t4_words", 32'(n_words), 32'd1024);
        chk("t4_done", 32'(n_done), 32'd1);
        chk("t4_abort", 32'(n_abort), 32'd0);
        chk("t4_idle", 32'(dump_valid), 32'd0);

        // Dump of L0K0 killed by conv_busy.
        dump_ready = 1'b1;
        start_dump(3'd1);
        for (int k = 0; k < 200 && n_words < 10; k++) cyc();
        chk("t5_reach10", 32'(n_words >= 10), 32'd1);
        conv_busy = 1'b1;
        cyc(3);
        chk("t5_abort", 32'(n_abort), 32'd1);
        chk("t5_nodone", 32'(n_done), 32'd0);
        for (int k = 0; k < 20; k++) begin
            chk("t5_novalid", 32'(dump_valid), 32'd0);
            cyc();
        end
        start_dump(3'd1);
        for (int k = 0; k < 20; k++) begin
            chk("t5_busy_ign", 32'(dump_valid), 32'd0);
            cyc();
        end
        chk("t5_no_words", 32'(n_words), 32'd0);
        chk("t5_no_pulse", 32'(n_done + n_abort), 32'd0);
        conv_busy = 1'b0;
        dump_ready = 1'b0;
        cyc(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
